// File: rtl/trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : trap_sequencer
// Description : Machine-mode trap/MRET sequencer. Commits trap CSRs, then
//               flushes the pipeline and redirects fetch to mtvec or mepc.
// Revision    : 1.0 - initial release
// ============================================================================
module trap_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET  = 32'h0000_0000,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic            i_exception_valid,
    input  logic [XLEN-1:0] i_exception_cause,
    input  logic [XLEN-1:0] i_exception_tval,
    input  logic [XLEN-1:0] i_program_counter,
    input  logic            i_is_mret,
    input  logic            i_interrupt_pending,
    input  logic [XLEN-2:0] i_interrupt_cause,
    input  logic            i_csr_we,
    input  logic [11:0]     i_csr_addr,
    input  logic [XLEN-1:0] i_csr_wdata,
    output logic [XLEN-1:0] o_csr_rdata,
    output logic            o_stall,
    output logic            o_flush,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_trap_taken,
    output logic            o_mret_taken,
    output logic            o_mie
);

    localparam logic [1:0]  c_idle        = 2'd0;
    localparam logic [1:0]  c_flush       = 2'd1;
    localparam logic [1:0]  c_redirect    = 2'd2;
    localparam logic [3:0]  c_flush_load  = 4'(FLUSH_CYCLES - 1);
    localparam logic [11:0] c_addr_status = 12'h300;
    localparam logic [11:0] c_addr_tvec   = 12'h305;
    localparam logic [11:0] c_addr_epc    = 12'h341;
    localparam logic [11:0] c_addr_cause  = 12'h342;
    localparam logic [11:0] c_addr_tval   = 12'h343;

    logic [1:0]      r_state;
    logic [3:0]      r_cnt;
    logic            r_mie;
    logic            r_mpie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;
    logic [XLEN-1:0] r_target;

    logic            w_is_idle;
    logic            w_take_exc;
    logic            w_take_irq;
    logic            w_take_trap;
    logic            w_take_mret;
    logic            w_take_we;
    logic [XLEN-1:0] w_mstatus;

    // Strict priority: exception > interrupt > MRET > CSR write, IDLE only.
    assign w_is_idle   = (r_state == c_idle);
    assign w_take_exc  = w_is_idle & i_valid & i_exception_valid;
    assign w_take_irq  = w_is_idle & ~w_take_exc & i_interrupt_pending & r_mie;
    assign w_take_trap = w_take_exc | w_take_irq;
    assign w_take_mret = w_is_idle & ~w_take_trap & i_valid & i_is_mret;
    assign w_take_we   = w_is_idle & ~w_take_trap & ~w_take_mret & i_valid & i_csr_we;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_idle;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_take_trap || w_take_mret) begin
                        r_state <= c_flush;
                        r_cnt   <= c_flush_load;
                    end
                end
                c_flush: begin
                    if (r_cnt == 4'd0) r_state <= c_redirect;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                c_redirect: r_state <= c_idle;
                default:    r_state <= c_idle;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mie    <= 1'b0;
            r_mpie   <= 1'b0;
            r_mtvec  <= MTVEC_RESET;
            r_mepc   <= '0;
            r_mcause <= '0;
            r_mtval  <= '0;
            r_target <= '0;
        end else if (w_take_trap) begin
            r_mepc   <= {i_program_counter[XLEN-1:1], 1'b0};
            r_mcause <= w_take_exc ? i_exception_cause : {1'b1, i_interrupt_cause};
            r_mtval  <= w_take_exc ? i_exception_tval : '0;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
            r_target <= {r_mtvec[XLEN-1:2], 2'b00};
        end else if (w_take_mret) begin
            r_mie    <= r_mpie;
            r_mpie   <= 1'b1;
            r_target <= r_mepc;
        end else if (w_take_we) begin
            case (i_csr_addr)
                c_addr_status: begin
                    r_mie  <= i_csr_wdata[3];
                    r_mpie <= i_csr_wdata[7];
                end
                c_addr_tvec:  r_mtvec  <= {i_csr_wdata[XLEN-1:2], 2'b00};
                c_addr_epc:   r_mepc   <= {i_csr_wdata[XLEN-1:1], 1'b0};
                c_addr_cause: r_mcause <= i_csr_wdata;
                c_addr_tval:  r_mtval  <= i_csr_wdata;
                default: ;
            endcase
        end
    end

    // MPP is hardwired to machine mode, so bits [12:11] always read as 2'b11.
    always_comb begin
        w_mstatus        = '0;
        w_mstatus[12:11] = 2'b11;
        w_mstatus[7]     = r_mpie;
        w_mstatus[3]     = r_mie;
    end

    always_comb begin
        o_csr_rdata = '0;
        case (i_csr_addr)
            c_addr_status: o_csr_rdata = w_mstatus;
            c_addr_tvec:   o_csr_rdata = r_mtvec;
            c_addr_epc:    o_csr_rdata = r_mepc;
            c_addr_cause:  o_csr_rdata = r_mcause;
            c_addr_tval:   o_csr_rdata = r_mtval;
            default:       o_csr_rdata = '0;
        endcase
    end

    assign o_stall          = ~w_is_idle;
    assign o_flush          = (r_state == c_flush);
    assign o_redirect_valid = (r_state == c_redirect);
    assign o_redirect_pc    = o_redirect_valid ? r_target : '0;
    assign o_trap_taken     = w_take_trap;
    assign o_mret_taken     = w_take_mret;
    assign o_mie            = r_mie;

endmodule
`default_nettype wire

// File: tb/tb_trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_sequencer
// Description : Scoreboard bench for trap_sequencer with a CSR/trap model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_sequencer;

    localparam int          XLEN      = 32;
    localparam int          F         = 2;
    localparam logic [31:0] MTVEC_RST = 32'h0000_0040;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid, i_exception_valid, i_is_mret, i_interrupt_pending, i_csr_we;
    logic [31:0] i_exception_cause, i_exception_tval, i_program_counter, i_csr_wdata;
    logic [30:0] i_interrupt_cause;
    logic [11:0] i_csr_addr;
    logic [31:0] o_csr_rdata, o_redirect_pc;
    logic        o_stall, o_flush, o_redirect_valid, o_trap_taken, o_mret_taken, o_mie;

    trap_sequencer #(.XLEN(XLEN), .MTVEC_RESET(MTVEC_RST), .FLUSH_CYCLES(F)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid),
        .i_exception_valid(i_exception_valid), .i_exception_cause(i_exception_cause),
        .i_exception_tval(i_exception_tval), .i_program_counter(i_program_counter),
        .i_is_mret(i_is_mret), .i_interrupt_pending(i_interrupt_pending),
        .i_interrupt_cause(i_interrupt_cause), .i_csr_we(i_csr_we),
        .i_csr_addr(i_csr_addr), .i_csr_wdata(i_csr_wdata), .o_csr_rdata(o_csr_rdata),
        .o_stall(o_stall), .o_flush(o_flush), .o_redirect_valid(o_redirect_valid),
        .o_redirect_pc(o_redirect_pc), .o_trap_taken(o_trap_taken),
        .o_mret_taken(o_mret_taken), .o_mie(o_mie)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct { logic [31:0] pc; int cyc; } exp_t;
    exp_t exp_q[$];

    // Architectural model of the trap CSRs
    logic        m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval;
    logic [11:0] addrs [6] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h343, 12'h7c0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mie = 1'b0; m_mpie = 1'b0; m_mtvec = MTVEC_RST;
        m_mepc = '0; m_mcause = '0; m_mtval = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 + (32'(m_mpie) * 128) + (32'(m_mie) * 8);
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            default: return 32'h0;
        endcase
    endfunction

    task automatic set_inputs(input logic v, input logic exc, input logic [31:0] cause,
                              input logic [31:0] tval, input logic [31:0] pc, input logic mret,
                              input logic irq, input logic [30:0] icause, input logic we,
                              input logic [11:0] addr, input logic [31:0] wdata);
        i_valid = v; i_exception_valid = exc; i_exception_cause = cause;
        i_exception_tval = tval; i_program_counter = pc; i_is_mret = mret;
        i_interrupt_pending = irq; i_interrupt_cause = icause; i_csr_we = we;
        i_csr_addr = addr; i_csr_wdata = wdata;
    endtask

    // One IDLE-state cycle; if an event is accepted, also walks the busy period.
    task automatic step(input logic v, input logic exc, input logic [31:0] cause,
                        input logic [31:0] tval, input logic [31:0] pc, input logic mret,
                        input logic irq, input logic [30:0] icause, input logic we,
                        input logic [11:0] addr, input logic [31:0] wdata);
        logic t_exc, t_irq, t_mret, t_we;
        exp_t e;
        set_inputs(v, exc, cause, tval, pc, mret, irq, icause, we, addr, wdata);
        t_exc  = v & exc;
        t_irq  = !t_exc & irq & m_mie;
        t_mret = !t_exc & !t_irq & v & mret;
        t_we   = !t_exc & !t_irq & !t_mret & v & we;
        @(negedge i_clk);
        chk("idle_stall", {31'b0, o_stall}, 32'h0);
        chk("trap_taken", {31'b0, o_trap_taken}, {31'b0, t_exc | t_irq});
        chk("mret_taken", {31'b0, o_mret_taken}, {31'b0, t_mret});
        chk("csr_rdata", o_csr_rdata, model_read(addr));
        chk("mie_out", {31'b0, o_mie}, {31'b0, m_mie});
        if (t_exc || t_irq) begin
            e.pc = {m_mtvec[31:2], 2'b00};
            e.cyc = cyc + 1 + F;
            exp_q.push_back(e);
        end else if (t_mret) begin
            e.pc = m_mepc;
            e.cyc = cyc + 1 + F;
            exp_q.push_back(e);
        end
        @(posedge i_clk); #1;
        if (t_exc || t_irq) begin
            m_mepc   = pc & ~32'h1;
            m_mcause = t_exc ? cause : {1'b1, icause};
            m_mtval  = t_exc ? tval : 32'h0;
            m_mpie   = m_mie;
            m_mie    = 1'b0;
        end else if (t_mret) begin
            m_mie  = m_mpie;
            m_mpie = 1'b1;
        end else if (t_we) begin
            case (addr)
                12'h300: begin m_mie = wdata[3]; m_mpie = wdata[7]; end
                12'h305: m_mtvec  = wdata & ~32'h3;
                12'h341: m_mepc   = wdata & ~32'h1;
                12'h342: m_mcause = wdata;
                12'h343: m_mtval  = wdata;
                default: ;
            endcase
        end
        if (t_exc || t_irq || t_mret) begin
            for (int j = 0; j <= F; j++) begin
                // Everything offered while busy must be ignored
                set_inputs($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom,
                           $urandom, $urandom, $urandom_range(0, 1) == 1, 1'b1, 31'($urandom),
                           1'b1, 12'h305, $urandom);
                @(negedge i_clk);
                chk("busy_stall", {31'b0, o_stall}, 32'h1);
                chk("busy_flush", {31'b0, o_flush}, {31'b0, j < F});
                chk("busy_no_trap", {30'b0, o_trap_taken, o_mret_taken}, 32'h0);
                @(posedge i_clk); #1;
            end
        end
    endtask

    task automatic idle(input logic [11:0] addr);
        step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 31'h0, 1'b0, addr, 32'h0);
    endtask

    task automatic peek(input string name, input logic [11:0] addr, input logic [31:0] exp);
        set_inputs(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 31'h0, 1'b0, addr, 32'h0);
        @(negedge i_clk);
        chk(name, o_csr_rdata, exp);
        @(posedge i_clk); #1;
    endtask

    // Monitor: every redirect must match the oldest outstanding expectation
    always @(negedge i_clk) begin
        if (o_redirect_valid) begin
            if (exp_q.size() == 0) begin
                chk("redirect_unexpected", 32'h1, 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("redirect_pc", o_redirect_pc, e.pc);
                chk("redirect_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        model_reset();
        set_inputs(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 31'h0, 1'b0, 12'h305, 32'h0);
        @(negedge i_clk);
        chk("rst_outputs", {26'b0, o_stall, o_flush, o_redirect_valid, o_trap_taken,
                            o_mret_taken, o_mie}, 32'h0);
        chk("rst_redirect_pc", o_redirect_pc, 32'h0);
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        peek("rst_mtvec", 12'h305, MTVEC_RST);
        peek("rst_mstatus", 12'h300, 32'h1800);
        peek("rst_mepc", 12'h341, 32'h0);

        // Load misalign
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 12'h305, 32'h100);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 12'h300, 32'h8);
        step(1, 1, 32'd4, 32'h1003, 32'h200, 0, 0, 0, 0, 12'h300, 0);
        peek("lm_mepc", 12'h341, 32'h200);
        peek("lm_mcause", 12'h342, 32'h4);
        peek("lm_mtval", 12'h343, 32'h1003);
        peek("lm_mstatus", 12'h300, 32'h1880);

        // MRET
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 12'h341, 32'h204);
        step(1, 0, 0, 0, 32'h204, 1, 0, 0, 0, 12'h300, 0);
        peek("mret_mstatus", 12'h300, 32'h1888);

        // Interrupt vs exception
        step(1, 1, 32'd11, 0, 32'h300, 0, 1, 31'd7, 0, 12'h342, 0);
        peek("ivx_mcause", 12'h342, 32'd11);
        step(1, 0, 0, 0, 32'h300, 1, 1, 31'd7, 0, 12'h300, 0);
        step(0, 0, 0, 0, 32'h400, 0, 1, 31'd7, 0, 12'h342, 0);
        peek("irq_mcause", 12'h342, 32'h8000_0007);
        peek("irq_mtval", 12'h343, 32'h0);
        peek("irq_mepc", 12'h341, 32'h400);

        // Masked interrupt
        for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 0, 0, 1, 31'd3, 0, 12'h300, 0);

        // CSR collisions
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 12'h305, 32'h303);
        peek("mtvec_align", 12'h305, 32'h300);
        step(1, 1, 32'd5, 32'h55, 32'h500, 0, 0, 0, 1, 12'h343, 32'hAA);
        peek("collide_mtval", 12'h343, 32'h55);

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom, $urandom,
                 $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                 31'($urandom), $urandom_range(0, 2) == 0, addrs[$urandom_range(0, 5)],
                 $urandom);
        end

        // Reset in the middle of FLUSH
        idle(12'h300);
        set_inputs(1'b1, 1'b1, 32'd2, 32'h0, 32'h600, 1'b0, 1'b0, 31'h0, 1'b0, 12'h305, 32'h0);
        @(negedge i_clk);
        @(posedge i_clk); #1;
        set_inputs(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 31'h0, 1'b0, 12'h305, 32'h0);
        chk("pre_rst_flush", {31'b0, o_flush}, 32'h1);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_stall", {31'b0, o_stall}, 32'h0);
        chk("midrst_flush", {31'b0, o_flush}, 32'h0);
        chk("midrst_mtvec", o_csr_rdata, MTVEC_RST);
        model_reset();
        exp_q.delete();
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        for (int k = 0; k < 6; k++) idle(12'h300);
        peek("postrst_mstatus", 12'h300, 32'h1800);

        chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
